// File: rtl/rr_select_arbiter.sv
// Round-robin select arbiter: grants up to NGRANT of WIDTH requesters per cycle from a rotating pointer.
// Optional starvation guard compiled in with RR_SELECT_STARVE_GUARD_EN.
module rr_select_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NGRANT   = 2,
  parameter int PW       = $clog2(WIDTH),
  parameter int MAX_WAIT = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WIDTH-1:0]              i_request,
  input  logic                          i_ready,
  output logic [NGRANT*WIDTH-1:0]       o_grant,
  output logic [NGRANT-1:0]             o_valid,
  output logic [$clog2(NGRANT+1)-1:0]   o_count,
  output logic                          o_empty,
  output logic [PW-1:0]                 o_ptr
);

  localparam int CW = $clog2(NGRANT+1);

  if (WIDTH < 2 || NGRANT < 1 || NGRANT > WIDTH || MAX_WAIT < 1) begin : g_param_check
    $error("rr_select_arbiter: illegal parameter combination");
  end

  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    forced_vld;
  logic [PW-1:0]           forced_idx;
  logic [WIDTH-1:0]        forced_mask;

  logic [NGRANT*WIDTH-1:0] grant_c;
  logic [NGRANT-1:0]       valid_c;
  logic [WIDTH-1:0]        granted_c;
  logic [CW-1:0]           count_c;
  logic                    any_normal;
  logic [PW-1:0]           last_idx;

  // Search from ptr_q upward with wrap; slots fill from 0 with no holes.
  always_comb begin
    logic [WIDTH-1:0] avail;
    int               filled;
    int               idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred;
    // blocking '=' is correct here because this is combinational logic, not state.
    grant_c    = '0;
    valid_c    = '0;
    any_normal = 1'b0;
    last_idx   = ptr_q;
    filled     = 0;
    avail      = i_request & ~forced_mask;
    if (forced_vld) begin
      grant_c[WIDTH-1:0] = forced_mask;
      valid_c[0]         = 1'b1;
      filled             = 1;
    end
    for (int off = 0; off < WIDTH; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (avail[idx] && filled < NGRANT) begin
        grant_c[filled*WIDTH + idx] = 1'b1;
        valid_c[filled]             = 1'b1;
        filled                      = filled + 1;
        any_normal                  = 1'b1;
        last_idx                    = PW'(idx);
      end
    end
    count_c = CW'(filled);
    if (!i_ready) begin
      grant_c    = '0;
      valid_c    = '0;
      count_c    = '0;
      any_normal = 1'b0;
    end
    granted_c = '0;
    for (int k = 0; k < NGRANT; k++) granted_c = granted_c | grant_c[k*WIDTH +: WIDTH];
  end

  always_comb begin
    logic [PW-1:0] base;
    ptr_d = ptr_q;
    base  = any_normal ? last_idx : forced_idx;
    if (i_ready && count_c != '0) begin
      ptr_d = (base == PW'(WIDTH-1)) ? '0 : base + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`ifdef RR_SELECT_STARVE_GUARD_EN
  localparam int CNTW = $clog2(MAX_WAIT+1);

  logic [CNTW-1:0] wait_q [WIDTH];
  logic [CNTW-1:0] wait_d [WIDTH];

  // Lowest-index requester whose wait count has saturated is forced into slot 0.
  always_comb begin
    forced_vld  = 1'b0;
    forced_idx  = '0;
    forced_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!forced_vld && i_request[i] && wait_q[i] == CNTW'(MAX_WAIT)) begin
        forced_vld     = 1'b1;
        forced_idx     = PW'(i);
        forced_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wait_d[i] = wait_q[i];
      if (i_ready) begin
        if (granted_c[i] || !i_request[i])     wait_d[i] = '0;
        else if (wait_q[i] != CNTW'(MAX_WAIT)) wait_d[i] = wait_q[i] + CNTW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: this counter array is architectural state, so it is reset like any other flop
    // (unlike a data RAM, whose contents need no reset).
    for (int i = 0; i < WIDTH; i++) begin
      if (i_rst) wait_q[i] <= '0;
      else       wait_q[i] <= wait_d[i];
    end
  end
`else
  assign forced_vld  = 1'b0;
  assign forced_idx  = '0;
  assign forced_mask = '0;
`endif

  assign o_grant = grant_c;
  assign o_valid = valid_c;
  assign o_count = count_c;
  assign o_empty = ~|i_request;
  assign o_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed self-checking bench for rr_select_arbiter in its default build (WIDTH=8, NGRANT=2).
module tb_rr_select_arbiter;

  localparam int W  = 8;
  localparam int NG = 2;

  logic          clk;
  logic          rst;
  logic [W-1:0]  req;
  logic          ready;
  logic [NG*W-1:0] grant;
  logic [NG-1:0] valid;
  logic [1:0]    count;
  logic          empty;
  logic [2:0]    ptr;

  int errors = 0;
  int checks = 0;

  rr_select_arbiter #(.WIDTH(W), .NGRANT(NG), .MAX_WAIT(15)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_request(req),
    .i_ready  (ready),
    .o_grant  (grant),
    .o_valid  (valid),
    .o_count  (count),
    .o_empty  (empty),
    .o_ptr    (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drive new inputs just after it.
  task automatic step(input logic r, input logic [W-1:0] rq, input logic rd);
    @(posedge clk);
    #1;
    rst   = r;
    req   = rq;
    ready = rd;
    @(negedge clk);
  endtask

  task automatic expect_grants(input string tag, input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input logic [1:0] v, input logic [1:0] c);
    check({tag, ".slot0"}, 32'(grant[W-1:0]), 32'(s0));
    check({tag, ".slot1"}, 32'(grant[2*W-1:W]), 32'(s1));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".count"}, 32'(count), 32'(c));
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    ready = 1'b1;
    @(negedge clk);
    check("reset.ptr", 32'(ptr), 32'd0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.count", 32'(count), 32'd0);

    // ptr 0, req 1011_0110: bits 1,2 granted, ptr -> 3
    step(1'b0, 8'b1011_0110, 1'b1);
    check("t1.ptr", 32'(ptr), 32'd0);
    expect_grants("t1", 8'h02, 8'h04, 2'b11, 2'd2);
    check("t1.empty", 32'(empty), 32'd0);
    step(1'b0, 8'b1011_0110, 1'b1);
    check("t2.ptr", 32'(ptr), 32'd3);
    expect_grants("t2", 8'h10, 8'h20, 2'b11, 2'd2);
    step(1'b0, 8'b1011_0110, 1'b1);
    check("t3.ptr", 32'(ptr), 32'd6);
    expect_grants("t3_wrap", 8'h80, 8'h02, 2'b11, 2'd2);

    // Stall for three cycles with all requesting: nothing granted, ptr holds at 2
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF, 1'b0);
      check("stall.ptr", 32'(ptr), 32'd2);
      expect_grants("stall", 8'h00, 8'h00, 2'b00, 2'd0);
      check("stall.empty", 32'(empty), 32'd0);
    end

    // No requests: empty, ptr holds
    step(1'b0, 8'h00, 1'b1);
    check("idle.empty", 32'(empty), 32'd1);
    expect_grants("idle", 8'h00, 8'h00, 2'b00, 2'd0);
    step(1'b0, 8'h80, 1'b1);
    check("idle.ptr_hold", 32'(ptr), 32'd2);
    expect_grants("single_top", 8'h80, 8'h00, 2'b01, 2'd1);

    // Last grant at WIDTH-1 wraps ptr to 0; then single bit 4 moves ptr to 5
    step(1'b0, 8'h10, 1'b1);
    check("wrap.ptr", 32'(ptr), 32'd0);
    expect_grants("single_b4", 8'h10, 8'h00, 2'b01, 2'd1);

    // Reset with grants visible: they are not committed
    step(1'b1, 8'hFF, 1'b1);
    check("pre_rst.ptr", 32'(ptr), 32'd5);
    expect_grants("in_rst", 8'h20, 8'h40, 2'b11, 2'd2);
    step(1'b0, 8'hFF, 1'b1);
    check("post_rst.ptr", 32'(ptr), 32'd0);
    expect_grants("post_rst", 8'h01, 8'h02, 2'b11, 2'd2);

    // Request changes during a stall: the later request alone decides
    step(1'b0, 8'h0C, 1'b0);
    check("stall2.ptr", 32'(ptr), 32'd2);
    expect_grants("stall2", 8'h00, 8'h00, 2'b00, 2'd0);
    step(1'b0, 8'h03, 1'b1);
    check("resume.ptr", 32'(ptr), 32'd2);
    expect_grants("resume_wrap", 8'h01, 8'h02, 2'b11, 2'd2);
    step(1'b0, 8'h00, 1'b1);
    check("resume.next_ptr", 32'(ptr), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
